// File: rtl/pika_pkg.sv
// Shared field geometry, serve points, state type and velocity saturation
// used by the Pikachu volleyball ball engine.
package pika_pkg;

  localparam int FIELD_W          = 320;
  localparam int FIELD_H          = 240;
  localparam int BALL_W           = 30;
  localparam int BALL_H           = 30;
  localparam int PIKA_W           = 41;
  localparam int PIKA_H           = 42;
  localparam int NET_X            = 156;
  localparam int NET_W            = 8;
  localparam int NET_Y            = 150;
  localparam int NET_H            = FIELD_H - NET_Y;
  localparam int FLOOR_Y          = 210;
  localparam int RIGHT_X          = 290;
  localparam int SERVE_X_PLAYER   = 245;
  localparam int SERVE_X_COMPUTER = 45;
  localparam int SERVE_Y          = 40;
  localparam int RESET_X          = 145;

  typedef enum logic [1:0] {
    IDLE,
    HOLD,
    FLIGHT,
    LANDED
  } ball_state_e;

  // Clamp a wide signed velocity into [-vmax, vmax] and narrow it to 6 bits.
  function automatic logic signed [5:0] sat_vel(input logic signed [12:0] v,
                                                input int vmax);
    logic signed [12:0] lim;
    lim = 13'(vmax);
    if (v > lim) return 6'(lim);
    if (v < -lim) return 6'(-lim);
    return 6'(v);
  endfunction

endpackage

// File: rtl/aabb_overlap.sv
// Combinational axis-aligned box overlap test between box A and box B,
// each given by its top-left corner and a compile-time size.
module aabb_overlap
  import pika_pkg::*;
#(
  parameter int A_W = BALL_W,
  parameter int A_H = BALL_H,
  parameter int B_W = PIKA_W,
  parameter int B_H = PIKA_H
) (
  input  logic signed [12:0] a_x,
  input  logic signed [12:0] a_y,
  input  logic signed [12:0] b_x,
  input  logic signed [12:0] b_y,
  output logic               overlap
);

  logic signed [13:0] ax, ay, bx, by;

  // One extra bit so a corner near the 12-bit limit plus a size cannot wrap.
  assign ax = 14'(a_x);
  assign ay = 14'(a_y);
  assign bx = 14'(b_x);
  assign by = 14'(b_y);

  assign overlap = (ax < bx + 14'(B_W)) && (bx < ax + 14'(A_W)) &&
                   (ay < by + 14'(B_H)) && (by < ay + 14'(A_H));

endmodule

// File: rtl/ball_engine.sv
// Per-frame ball physics: serve hold, flight integration, collisions and landing report.
// Net collision is built in only when BALL_ENGINE_NET_EN is defined.
module ball_engine
  import pika_pkg::*;
#(
  parameter int SERVE_DELAY = 60,
  parameter int GRAVITY     = 1,
  parameter int HIT_VY      = 12,
  parameter int VMAX        = 15
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        frame_tick,
  input  logic        serve,
  input  logic        serve_to_player,
  output logic        serve_ready,
  input  logic [11:0] player_x_position,
  input  logic [11:0] player_y_position,
  input  logic [11:0] computer_x_position,
  input  logic [11:0] computer_y_position,
  output logic [11:0] ball_x_position,
  output logic [11:0] ball_y_position,
  output logic        ball_active,
  output logic        point_valid,
  output logic        point_to_player,
  input  logic        point_ack
);

  localparam int CNT_W = $clog2(SERVE_DELAY + 1);

  ball_state_e        state_q, state_d;
  logic [11:0]        x_q, x_d, y_q, y_d;
  logic signed [5:0]  vx_q, vx_d, vy_q, vy_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               serve_ready_q, serve_ready_d;
  logic               ball_active_q, ball_active_d;
  logic               point_valid_q, point_valid_d;
  logic               point_to_player_q, point_to_player_d;

  logic signed [12:0] x_s, y_s, nx, ny, px_s, py_s, cx_s, cy_s, hit_dx;
  logic signed [5:0]  vy_g, hit_vx, neg_vx, neg_vy;
  logic               hit_player, hit_computer, net_hit, net_top;
  logic signed [12:0] f_x, f_y;
  logic signed [5:0]  f_vx, f_vy;
  logic               f_land, f_left;

  assign x_s  = $signed({1'b0, x_q});
  assign y_s  = $signed({1'b0, y_q});
  assign px_s = $signed({1'b0, player_x_position});
  assign py_s = $signed({1'b0, player_y_position});
  assign cx_s = $signed({1'b0, computer_x_position});
  assign cy_s = $signed({1'b0, computer_y_position});

  assign vy_g   = sat_vel(13'(vy_q) + 13'(GRAVITY), VMAX);
  assign nx     = x_s + 13'(vx_q);
  assign ny     = y_s + 13'(vy_g);
  assign neg_vx = sat_vel(-13'(vx_q), VMAX);
  assign neg_vy = sat_vel(-13'(vy_g), VMAX);

  // Deflection follows the offset between ball centre and Pikachu centre.
  assign hit_dx = (nx + 13'(BALL_W / 2)) - ((hit_player ? px_s : cx_s) + 13'(PIKA_W / 2));
  assign hit_vx = sat_vel(hit_dx >>> 2, VMAX);

  aabb_overlap #(.A_W(BALL_W), .A_H(BALL_H), .B_W(PIKA_W), .B_H(PIKA_H)) u_player_hit (
    .a_x(nx), .a_y(ny), .b_x(px_s), .b_y(py_s), .overlap(hit_player)
  );

  aabb_overlap #(.A_W(BALL_W), .A_H(BALL_H), .B_W(PIKA_W), .B_H(PIKA_H)) u_computer_hit (
    .a_x(nx), .a_y(ny), .b_x(cx_s), .b_y(cy_s), .overlap(hit_computer)
  );

`ifdef BALL_ENGINE_NET_EN
  aabb_overlap #(.A_W(BALL_W), .A_H(BALL_H), .B_W(NET_W), .B_H(NET_H)) u_net_hit (
    .a_x(nx), .a_y(ny), .b_x(13'(NET_X)), .b_y(13'(NET_Y)), .overlap(net_hit)
  );
`else
  assign net_hit = 1'b0;
`endif

  always_comb begin
    f_x     = nx;
    f_y     = ny;
    f_vx    = vx_q;
    f_vy    = vy_g;
    f_land  = 1'b0;
    net_top = 1'b0;
    if (hit_player || hit_computer) begin
      f_y  = y_s;
      f_vx = hit_vx;
      f_vy = sat_vel(-13'(HIT_VY), VMAX);
    end else begin
      // Landing on top of the net only when the ball was fully above it last frame.
      net_top = net_hit && (y_s + 13'(BALL_H) <= 13'(NET_Y));
      if (net_hit && !net_top) begin
        f_x  = x_s;
        f_vx = neg_vx;
      end else if (nx < 13'sd0) begin
        f_x  = 13'sd0;
        f_vx = neg_vx;
      end else if (nx > 13'(RIGHT_X)) begin
        f_x  = 13'(RIGHT_X);
        f_vx = neg_vx;
      end
      if (net_top) begin
        f_y  = 13'(NET_Y - BALL_H);
        f_vy = neg_vy;
      end else if (ny < 13'sd0) begin
        f_y  = 13'sd0;
        f_vy = neg_vy;
      end else if (ny >= 13'(FLOOR_Y)) begin
        f_y    = 13'(FLOOR_Y);
        f_land = 1'b1;
      end
    end
  end

  assign f_left = (f_x + 13'(BALL_W / 2)) < 13'(FIELD_W / 2);

  always_comb begin
    state_d           = state_q;
    x_d               = x_q;
    y_d               = y_q;
    vx_d              = vx_q;
    vy_d              = vy_q;
    cnt_d             = cnt_q;
    serve_ready_d     = serve_ready_q;
    ball_active_d     = ball_active_q;
    point_valid_d     = point_valid_q;
    point_to_player_d = point_to_player_q;
    case (state_q)
      IDLE: begin
        if (serve && serve_ready_q) begin
          state_d       = HOLD;
          x_d           = serve_to_player ? 12'(SERVE_X_PLAYER) : 12'(SERVE_X_COMPUTER);
          y_d           = 12'(SERVE_Y);
          vx_d          = '0;
          vy_d          = '0;
          cnt_d         = '0;
          serve_ready_d = 1'b0;
          ball_active_d = 1'b1;
        end
      end
      HOLD: begin
        if (frame_tick) begin
          if (cnt_q == CNT_W'(SERVE_DELAY - 1)) state_d = FLIGHT;
          else cnt_d = cnt_q + 1'b1;
        end
      end
      FLIGHT: begin
        if (frame_tick) begin
          x_d  = 12'(f_x);
          y_d  = 12'(f_y);
          vx_d = f_vx;
          vy_d = f_vy;
          if (f_land) begin
            state_d           = LANDED;
            vx_d              = '0;
            vy_d              = '0;
            ball_active_d     = 1'b0;
            point_valid_d     = 1'b1;
            point_to_player_d = f_left;
          end
        end
      end
      LANDED: begin
        if (point_ack && point_valid_q) begin
          state_d       = IDLE;
          point_valid_d = 1'b0;
          serve_ready_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q           <= IDLE;
      x_q               <= 12'(RESET_X);
      y_q               <= 12'(SERVE_Y);
      vx_q              <= '0;
      vy_q              <= '0;
      cnt_q             <= '0;
      serve_ready_q     <= 1'b1;
      ball_active_q     <= 1'b0;
      point_valid_q     <= 1'b0;
      point_to_player_q <= 1'b0;
    end else begin
      state_q           <= state_d;
      x_q               <= x_d;
      y_q               <= y_d;
      vx_q              <= vx_d;
      vy_q              <= vy_d;
      cnt_q             <= cnt_d;
      serve_ready_q     <= serve_ready_d;
      ball_active_q     <= ball_active_d;
      point_valid_q     <= point_valid_d;
      point_to_player_q <= point_to_player_d;
    end
  end

  assign serve_ready     = serve_ready_q;
  assign ball_active     = ball_active_q;
  assign point_valid     = point_valid_q;
  assign point_to_player = point_to_player_q;
  assign ball_x_position = x_q;
  assign ball_y_position = y_q;

endmodule
